fifo_rd_drain: RTL and testbench

Read-side drain engine for the flip-flop FIFO. It watches `empty`/`occup` on the FIFO read port and issues `rd_en` in bursts once a fill threshold is reached, or unconditionally under `flush`. Returned words are captured into a 3-entry output buffer and presented on a valid/ready stream with a last-word tag. It runs entirely in the FIFO read clock domain, between the FIFO and the downstream consumer.

---
 rtl/fifo_rd_drain.sv | 208 ++++++++++++++++++++
 tb/tb_fifo_rd_drain.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// ----------------------------------------------------------------------------
// fifo_rd_drain
//
// Read-side drain engine for the flip-flop FIFO. It watches the FIFO read-port
// status and issues pops in bursts. A burst opens once the occupancy reaches
// BURST_MIN, or at any time while flush is high. Popped words land in a
// 3-entry circular buffer that feeds a valid/ready stream. Each word carries a
// tag marking the word that was the only entry in the FIFO when it was popped.
//
// Parameters
//   WIDTH      data width (matches FIFO rd_data)
//   DEPTH      FIFO depth; occup is $clog2(DEPTH)+1 bits
//   BURST_MIN  occupancy that opens a burst (1..DEPTH)
//
// Ports
//   clk_r      in   read-domain clock
//   rst_r      in   synchronous active-high reset
//   empty      in   FIFO empty flag (registered in the FIFO)
//   occup      in   FIFO occupancy
//   rd_data    in   FIFO read data, valid the cycle after rd_en
//   rd_en      out  FIFO pop request
//   flush      in   level; forces draining regardless of occup
//   out_valid  out  stream word valid
//   out_ready  in   consumer accepts the word
//   out_data   out  stream data
//   out_last   out  word was the only FIFO entry when it was popped
//   busy       out  streaming, or buffer / in-flight slot occupied
// ----------------------------------------------------------------------------

// Simulation-only checker: the buffer plus the in-flight slot never exceeds
// the three available entries.
module fifo_rd_drain_chk (
    input logic       clk_r,
    input logic       rst_r,
    input logic [1:0] buf_cnt,
    input logic       inflight
);

    // Flag any cycle where outstanding words exceed buffer capacity.
    always_ff @(posedge clk_r) begin
        if (!rst_r) begin
            assert (({1'b0, buf_cnt} + {2'b00, inflight}) <= 3'd3)
            else $error("fifo_rd_drain: credit overflow buf_cnt=%0d inflight=%0d",
                        buf_cnt, inflight);
        end
    end

endmodule

module fifo_rd_drain #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int BURST_MIN = 4
) (
    input  logic                     clk_r,
    input  logic                     rst_r,
    input  logic                     empty,
    input  logic [$clog2(DEPTH):0]   occup,
    input  logic [WIDTH-1:0]         rd_data,
    output logic                     rd_en,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    output logic                     busy
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             inflight_r;
    logic             tag_r;
    logic [1:0]       head_r;
    logic [1:0]       tail_r;
    logic [1:0]       buf_cnt_r;
    logic             out_valid_r;
    logic             busy_r;
    logic [WIDTH-1:0] buf_data_r [3];
    logic             buf_last_r [3];

    logic             credit_ok_s;
    logic             push_s;
    logic             pop_s;
    logic [1:0]       head_nxt_s;
    logic [1:0]       tail_nxt_s;
    logic [1:0]       cnt_nxt_s;

    // Three-entry pointer advance: 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'd2) ? 2'd0 : (ptr + 2'd1);
    endfunction

    // Burst open/close decisions.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if ((occup >= OCC_W'(BURST_MIN)) || flush) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                // Dropping flush mid-burst does not end it; only empty does.
                if (empty && !flush) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Pop request: only with a free buffer slot for every outstanding word.
    // Deliberately independent of out_ready; gated off while reset is held.
    always_comb begin
        credit_ok_s = (({1'b0, buf_cnt_r} + {2'b00, inflight_r}) < 3'd3);
        if (!rst_r && (state_r == ST_STREAM) && !empty && credit_ok_s) begin
            rd_en = 1'b1;
        end else begin
            rd_en = 1'b0;
        end
    end

    // Buffer pointer and occupancy bookkeeping.
    always_comb begin
        push_s     = inflight_r;
        pop_s      = (buf_cnt_r != 2'd0) && out_ready;
        head_nxt_s = head_r;
        tail_nxt_s = tail_r;
        cnt_nxt_s  = buf_cnt_r;
        if (pop_s) begin
            head_nxt_s = ptr_inc(head_r);
        end else begin
            head_nxt_s = head_r;
        end
        if (push_s) begin
            tail_nxt_s = ptr_inc(tail_r);
        end else begin
            tail_nxt_s = tail_r;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = buf_cnt_r + 2'd1;
            2'b01:   cnt_nxt_s = buf_cnt_r - 2'd1;
            default: cnt_nxt_s = buf_cnt_r;
        endcase
    end

    // Control state, in-flight tracking and registered status outputs.
    always_ff @(posedge clk_r) begin
        if (rst_r) begin
            state_r     <= ST_IDLE;
            inflight_r  <= 1'b0;
            tag_r       <= 1'b0;
            head_r      <= 2'd0;
            tail_r      <= 2'd0;
            buf_cnt_r   <= 2'd0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            inflight_r  <= rd_en;
            // The tag is taken at pop time, so a same-cycle FIFO write cannot
            // clear it; it rides alongside the word still in flight.
            tag_r       <= rd_en ? (occup == OCC_W'(1)) : tag_r;
            head_r      <= head_nxt_s;
            tail_r      <= tail_nxt_s;
            buf_cnt_r   <= cnt_nxt_s;
            out_valid_r <= (cnt_nxt_s != 2'd0);
            busy_r      <= (state_nxt_s == ST_STREAM) || (cnt_nxt_s != 2'd0) || rd_en;
        end
    end

    // Buffer storage; entries only change at the tail so the head stays stable.
    always_ff @(posedge clk_r) begin
        if (rst_r) begin
            for (int i = 0; i < 3; i++) begin
                buf_data_r[i] <= '0;
                buf_last_r[i] <= 1'b0;
            end
        end else if (push_s) begin
            buf_data_r[tail_r] <= rd_data;
            buf_last_r[tail_r] <= tag_r;
        end
    end

    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_data  = buf_data_r[head_r];
    assign out_last  = buf_last_r[head_r];

    fifo_rd_drain_chk u_chk (
        .clk_r    (clk_r),
        .rst_r    (rst_r),
        .buf_cnt  (buf_cnt_r),
        .inflight (inflight_r)
    );

endmodule

// File: tb/tb_fifo_rd_drain.sv
// ----------------------------------------------------------------------------
// tb_fifo_rd_drain
//
// Directed bench for fifo_rd_drain. A queue-based FIFO model drives empty,
// occup and rd_data; every word written is pushed to a scoreboard with its
// expected last tag and popped when the stream delivers a beat.
// ----------------------------------------------------------------------------
module tb_fifo_rd_drain;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 16;
    localparam int BURST_MIN = 4;
    localparam int OCC_W     = 5;

    logic             clk_r = 1'b0;
    logic             rst_r;
    logic             empty;
    logic [OCC_W-1:0] occup;
    logic [WIDTH-1:0] rd_data;
    logic             rd_en;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;

    always #5 clk_r = ~clk_r;

    fifo_rd_drain #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .BURST_MIN (BURST_MIN)
    ) dut (
        .clk_r     (clk_r),
        .rst_r     (rst_r),
        .empty     (empty),
        .occup     (occup),
        .rd_data   (rd_data),
        .rd_en     (rd_en),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    int               checks = 0;
    int               errors = 0;
    int               cycle = 0;
    int               rd_cnt = 0;
    int               first_rd_cyc = -1;
    int               beat_cyc [$];
    logic [WIDTH-1:0] fifo_q [$];
    logic [WIDTH-1:0] wr_pending [$];
    logic [WIDTH:0]   exp_q [$];
    logic             hold_v = 1'b0;
    logic [WIDTH:0]   hold_w = '0;
    logic             s_valid;
    logic             s_busy;
    int               rc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, then advance the FIFO model after posedge.
    task automatic step();
        logic           rd_s;
        logic [WIDTH:0] obs_w;
        logic [WIDTH:0] exp_w;
        @(negedge clk_r);
        rd_s    = rd_en;
        s_valid = out_valid;
        s_busy  = busy;
        obs_w   = {out_last, out_data};
        if (rd_s) begin
            rd_cnt++;
            if (first_rd_cyc < 0) first_rd_cyc = cycle;
            chk("pop_on_nonempty", 64'(fifo_q.size() != 0), 64'd1);
        end
        if (hold_v) chk("hold_stable", 64'({out_valid, obs_w}), 64'({1'b1, hold_w}));
        if (out_valid && out_ready) begin
            beat_cyc.push_back(cycle);
            chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                chk("beat_word", 64'(obs_w), 64'(exp_w));
            end
        end
        hold_v = out_valid && !out_ready;
        hold_w = obs_w;
        @(posedge clk_r);
        #1;
        cycle++;
        if (rst_r) begin
            fifo_q.delete();
            wr_pending.delete();
            rd_data = '0;
            hold_v  = 1'b0;
        end else begin
            if (rd_s && (fifo_q.size() != 0)) rd_data = fifo_q.pop_front();
            while (wr_pending.size() != 0) fifo_q.push_back(wr_pending.pop_front());
        end
        empty = (fifo_q.size() == 0);
        occup = OCC_W'(fifo_q.size());
    endtask

    task automatic push_one(input logic [WIDTH-1:0] data, input logic last);
        wr_pending.push_back(data);
        exp_q.push_back({last, data});
    endtask

    // Bulk preload: all n words appear in the FIFO at the next edge.
    task automatic push_words(input int n, input logic [WIDTH-1:0] base);
        for (int i = 0; i < n; i++) push_one(base + WIDTH'(i), (i == n - 1));
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic settle();
        repeat (4) step();
    endtask

    initial begin
        rst_r     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        empty     = 1'b0;
        occup     = OCC_W'(8);
        rd_data   = '0;

        // Reset held with a non-empty FIFO view.
        @(posedge clk_r);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_r);
            chk("rst_rd_en", 64'(rd_en), 64'd0);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_out_data", 64'({out_last, out_data}), 64'd0);
            @(posedge clk_r);
        end
        #1;
        for (int i = 0; i < 8; i++) begin
            fifo_q.push_back(32'hB000_0000 + 32'(i));
            exp_q.push_back({(i == 7), 32'hB000_0000 + 32'(i)});
        end
        empty = 1'b0;
        occup = OCC_W'(8);
        rst_r = 1'b0;
        step();
        chk("release_no_rd", 64'(rd_cnt), 64'd0);
        step();
        chk("first_rd_after_release", 64'(rd_cnt), 64'd1);
        drain("release_drain", 40);
        settle();
        chk("release_idle_busy", 64'(s_busy), 64'd0);

        // Below threshold, then the fourth word opens the burst.
        push_one(32'hA000_0001, 1'b0); step();
        push_one(32'hA000_0002, 1'b0); step();
        push_one(32'hA000_0003, 1'b0); step();
        rc = rd_cnt;
        repeat (20) step();
        chk("thresh_no_rd", 64'(rd_cnt - rc), 64'd0);
        chk("thresh_no_valid", 64'(s_valid), 64'd0);
        push_one(32'hA000_0004, 1'b1);
        drain("thresh_drain", 30);
        chk("thresh_pops", 64'(rd_cnt - rc), 64'd4);
        settle();

        // Full rate: 16 beats back to back, two cycles behind the first pop.
        first_rd_cyc = -1;
        beat_cyc.delete();
        rc = rd_cnt;
        push_words(16, 32'hC000_0000);
        drain("fr_drain", 60);
        chk("fr_pops", 64'(rd_cnt - rc), 64'd16);
        chk("fr_beats", 64'(beat_cyc.size()), 64'd16);
        for (int k = 0; k < beat_cyc.size(); k++)
            chk("fr_beat_cycle", 64'(beat_cyc[k]), 64'(first_rd_cyc + 2 + k));
        settle();

        // Backpressure: three pops fill the credit, then one free slot re-reads.
        out_ready = 1'b0;
        rc = rd_cnt;
        push_words(10, 32'hD000_0000);
        repeat (15) step();
        chk("bp_pops", 64'(rd_cnt - rc), 64'd3);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_head", 64'(out_data), 64'hD000_0000);
        out_ready = 1'b1;
        rc = rd_cnt;
        step();
        chk("bp_no_rd_while_full", 64'(rd_cnt - rc), 64'd0);
        step();
        chk("bp_reread", 64'(rd_cnt - rc), 64'd1);
        drain("bp_drain", 40);
        settle();

        // Flush: two words below threshold, drained by a one-cycle flush pulse.
        rc = rd_cnt;
        push_words(2, 32'hE000_0000);
        repeat (6) step();
        chk("flush_wait", 64'(rd_cnt - rc), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drain("flush_drain", 20);
        chk("flush_pops", 64'(rd_cnt - rc), 64'd2);
        settle();
        chk("flush_idle_busy", 64'(s_busy), 64'd0);

        // Reset with two buffered words and one in flight.
        out_ready = 1'b0;
        rc = rd_cnt;
        push_words(10, 32'hF000_0000);
        for (int i = 0; i < 20 && (rd_cnt - rc) < 3; i++) step();
        chk("mid_pops", 64'(rd_cnt - rc), 64'd3);
        rst_r = 1'b1;
        exp_q.delete();
        step();
        chk("mid_rst_rd_gate", 64'(rd_cnt - rc), 64'd3);
        rst_r = 1'b0;
        out_ready = 1'b1;
        step();
        chk("mid_rst_valid", 64'(s_valid), 64'd0);
        chk("mid_rst_busy", 64'(s_busy), 64'd0);
        rc = rd_cnt;
        push_words(5, 32'h1234_0000);
        drain("mid_refill_drain", 30);
        chk("mid_refill_pops", 64'(rd_cnt - rc), 64'd5);
        settle();
        chk("mid_final_busy", 64'(s_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
